// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - multi-source writeback commit stage with round-robin drain
// One holding register per source; one held entry commits per cycle onto the register-file port.
module wb_commit_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  localparam int PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int NREG      = 1 << REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC-1:0]            src_regwrite,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_addr,
  input  logic [NUM_SRC*XLEN-1:0]       src_rd_data,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_addr,
  output logic [XLEN-1:0]               rf_data,
  output logic                          fwd_regwrite,
  output logic [REG_ADDR_W-1:0]         fwd_rd_addr,
  output logic [XLEN-1:0]               fwd_rd_data,
  output logic [NREG-1:0]               pending_mask,
  output logic [PTR_W-1:0]              commit_src,
  output logic [CNT_W-1:0]              retire_cnt
);

  logic [NUM_SRC-1:0]    held_q, held_d;
  logic [NUM_SRC-1:0]    we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q [NUM_SRC];
  logic [REG_ADDR_W-1:0] addr_d [NUM_SRC];
  logic [XLEN-1:0]       data_q [NUM_SRC];
  logic [XLEN-1:0]       data_d [NUM_SRC];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

  logic [NUM_SRC-1:0]    grant;
  logic                  gnt_valid;
  logic [PTR_W-1:0]      gnt_idx;
  int                    idx;

  // First held entry at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!gnt_valid && held_q[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
    if (gnt_valid) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    src_ready    = ~held_q | grant;
    rf_we        = gnt_valid ? we_q[gnt_idx] : 1'b0;
    rf_addr      = gnt_valid ? addr_q[gnt_idx] : '0;
    rf_data      = gnt_valid ? data_q[gnt_idx] : '0;
    fwd_regwrite = rf_we;
    fwd_rd_addr  = rf_addr;
    fwd_rd_data  = rf_data;
    commit_src   = gnt_idx;
    retire_cnt   = retire_cnt_q;
    pending_mask = '0;
    // we_q is never set for x0, so bit 0 stays clear.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (held_q[i] && we_q[i] && !grant[i]) pending_mask[addr_q[i]] = 1'b1;
    end
  end

  always_comb begin
    held_d = held_q;
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        held_d[i] = 1'b1;
        addr_d[i] = src_rd_addr[i*REG_ADDR_W +: REG_ADDR_W];
        data_d[i] = src_rd_data[i*XLEN +: XLEN];
        we_d[i]   = src_regwrite[i] && (src_rd_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      end else if (grant[i]) begin
        held_d[i] = 1'b0;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + PTR_W'(1);
    end
    retire_cnt_d = retire_cnt_q + CNT_W'(gnt_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q       <= '0;
      we_q         <= '0;
      rr_ptr_q     <= '0;
      retire_cnt_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      held_q       <= held_d;
      we_q         <= we_d;
      rr_ptr_q     <= rr_ptr_d;
      retire_cnt_q <= retire_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb/tb_wb_commit_arbiter.sv - scoreboard bench for wb_commit_arbiter (NUM_SRC=3, CNT_W=4)
module tb_wb_commit_arbiter;
  localparam int NS = 3;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [XL-1:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS-1:0]    src_valid, src_ready, src_regwrite;
  logic [NS*AW-1:0] src_rd_addr;
  logic [NS*XL-1:0] src_rd_data;
  logic             rf_we, fwd_regwrite;
  logic [AW-1:0]    rf_addr, fwd_rd_addr;
  logic [XL-1:0]    rf_data, fwd_rd_data;
  logic [31:0]      pending_mask;
  logic [1:0]       commit_src;
  logic [CW-1:0]    retire_cnt;

  logic [AW-1:0] ad [NS];
  logic [XL-1:0] dt [NS];
  ent_t          sq [NS][$];
  int            clog [$];
  logic [CW-1:0] exp_cnt;
  int            ncmp = 0;
  int            nfail = 0;

  assign src_rd_addr = {ad[2], ad[1], ad[0]};
  assign src_rd_data = {dt[2], dt[1], dt[0]};

  wb_commit_arbiter #(.NUM_SRC(NS), .XLEN(XL), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_regwrite(src_regwrite),
    .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .fwd_regwrite(fwd_regwrite), .fwd_rd_addr(fwd_rd_addr), .fwd_rd_data(fwd_rd_data),
    .pending_mask(pending_mask), .commit_src(commit_src), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, checks against the model, then advances one rising edge.
  task automatic cycle();
    bit            any;
    int            g;
    ent_t          e;
    logic [31:0]   pm;
    logic [NS-1:0] rdy;
    @(negedge clk);
    any = 0;
    for (int i = 0; i < NS; i++) if (sq[i].size() != 0) any = 1;
    g = int'(commit_src);
    chk("retire_cnt", retire_cnt, exp_cnt);
    if (any) begin
      chk("grant_held", (g < NS) && (sq[g < NS ? g : 0].size() != 0), 1);
      if (g < NS && sq[g].size() != 0) begin
        e = sq[g][0];
        chk("rf_we", rf_we, e.we);
        chk("rf_addr", rf_addr, e.a);
        chk("rf_data", rf_data, e.d);
        chk("fwd", {fwd_regwrite, fwd_rd_addr, fwd_rd_data}, {e.we, e.a, e.d});
      end
    end else begin
      chk("idle_rf", {rf_we, rf_addr, rf_data}, 0);
      chk("idle_fwd", {fwd_regwrite, fwd_rd_addr, fwd_rd_data}, 0);
      chk("idle_commit_src", commit_src, 0);
    end
    pm = '0;
    for (int i = 0; i < NS; i++) begin
      if (sq[i].size() != 0 && !(any && i == g) && sq[i][0].we) pm[sq[i][0].a] = 1'b1;
      rdy[i] = (sq[i].size() == 0) || (any && i == g);
    end
    chk("pending_mask", pending_mask, pm);
    chk("src_ready", src_ready, rdy);
    if (any && g < NS && sq[g].size() != 0) begin
      void'(sq[g].pop_front());
      clog.push_back(g);
      exp_cnt = exp_cnt + 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i] && rdy[i]) sq[i].push_back({src_regwrite[i] && ad[i] != '0, ad[i], dt[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0;
    for (int i = 0; i < NS; i++) sq[i].delete();
    clog.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    src_valid = '0;
    src_regwrite = '1;
    for (int i = 0; i < NS; i++) begin
      ad[i] = '0;
      dt[i] = '0;
    end
    exp_cnt = '0;
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_ready", src_ready, 3'b111);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_commit_src", commit_src, 0);
    do_reset();

    // Single source, back-to-back x5/x6/x7
    src_valid = 3'b001;
    ad[0] = 5'd5; dt[0] = 32'h11; cycle();
    ad[0] = 5'd6; dt[0] = 32'h22; cycle();
    ad[0] = 5'd7; dt[0] = 32'h33; cycle();
    src_valid = '0;
    cycle();
    cycle();
    chk("b2b_retire", retire_cnt, 3);

    // Round-robin fairness with every source valid
    do_reset();
    src_valid = 3'b111;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < NS; i++) begin
        ad[i] = AW'(8 + i * 4 + (c % 4));
        dt[i] = 32'h1000 * (i + 1) + c;
      end
      cycle();
    end
    src_valid = '0;
    for (int c = 0; c < 4; c++) cycle();
    chk("rr_count", clog.size(), 9);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_seq%0d", k), clog.size() > k ? clog[k] : -1, k % 3);

    // x0 write and RegWrite=0 both retire without writing
    do_reset();
    src_valid = 3'b010;
    ad[1] = 5'd0; dt[1] = 32'hDEAD; src_regwrite = 3'b111; cycle();
    ad[1] = 5'd9; dt[1] = 32'hBEEF; src_regwrite = 3'b101; cycle();
    src_valid = '0; src_regwrite = '1;
    chk("x0_pend9", pending_mask[9], 0);
    cycle();
    chk("x0_retire", retire_cnt, 2);

    // Pending mask while source 0 commits x3 ahead of source 1's x4
    do_reset();
    src_valid = 3'b011;
    ad[0] = 5'd3; dt[0] = 32'h3333;
    ad[1] = 5'd4; dt[1] = 32'h4444;
    cycle();
    src_valid = '0;
    chk("pm_0x10", pending_mask, 32'h10);
    chk("pm_src0", commit_src, 0);
    cycle();
    chk("pm_0x00", pending_mask, 32'h0);
    cycle();
    cycle();

    // Counter wrap: 17 commits with a 4-bit counter
    do_reset();
    src_valid = 3'b001;
    for (int c = 0; c < 17; c++) begin
      ad[0] = AW'(1 + c % 31); dt[0] = 32'hA000 + c;
      cycle();
    end
    src_valid = '0;
    cycle();
    chk("wrap_cnt", retire_cnt, 1);

    // Mid-run reset with three entries held
    do_reset();
    src_valid = 3'b111;
    for (int i = 0; i < NS; i++) begin
      ad[i] = AW'(20 + i); dt[i] = 32'hC0 + i;
    end
    cycle();
    src_valid = 3'b111;
    cycle();
    src_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_pending", pending_mask, 0);
    chk("mid_rst_ready", src_ready, 3'b111);
    chk("mid_rst_cnt", retire_cnt, 0);
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    chk("post_rst_cnt", retire_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
